// File: rtl/draw_rect_layers.sv
// draw_rect_layers: double-buffered multi-rectangle compositor with a 2-stage pixel pipeline
module draw_rect_layers #(
  parameter int NUM_RECTS = 4,
  parameter int OUTLINE_W = 2,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  localparam int IW = NUM_RECTS > 1 ? $clog2(NUM_RECTS) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [10:0]   hcount_in,
  input  logic [9:0]    vcount_in,
  input  logic          new_frame_in,
  input  logic          wr_valid_in,
  output logic          wr_ready_out,
  input  logic [IW-1:0] wr_idx_in,
  input  logic [10:0]   wr_x1_in,
  input  logic [10:0]   wr_x2_in,
  input  logic [9:0]    wr_y1_in,
  input  logic [9:0]    wr_y2_in,
  input  logic [23:0]   wr_color_in,
  input  logic          wr_enable_in,
  input  logic          wr_outline_in,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic          hit_out,
  output logic [IW-1:0] hit_idx_out
);
  typedef struct packed {
    logic [10:0] xl;
    logic [10:0] xh;
    logic [9:0]  yl;
    logic [9:0]  yh;
    logic [23:0] col;
    logic        en;
    logic        ol;
  } slot_t;

  slot_t shadow [NUM_RECTS];
  slot_t active [NUM_RECTS];
  slot_t ws;
  logic ready_q, acc;
  logic hit1_d, hit1_q;
  logic [IW-1:0] idx1_d, idx1_q;
  logic [23:0] col1_d, col1_q;

  function automatic logic covers(slot_t s, logic [10:0] h, logic [9:0] v);
    logic in_r, in_i;
    in_r = s.en && h >= s.xl && h < s.xh && v >= s.yl && v < s.yh;
    in_i = 32'(h) >= 32'(s.xl) + 32'(OUTLINE_W) && 32'(h) + 32'(OUTLINE_W) < 32'(s.xh) &&
           32'(v) >= 32'(s.yl) + 32'(OUTLINE_W) && 32'(v) + 32'(OUTLINE_W) < 32'(s.yh);
    return in_r && !(s.ol && in_i);
  endfunction

  assign wr_ready_out = ready_q & ~rst_in & ~new_frame_in;
  assign acc = wr_valid_in & wr_ready_out & (32'(wr_idx_in) < NUM_RECTS);

  always_comb begin
    ws.xl = wr_x1_in < wr_x2_in ? wr_x1_in : wr_x2_in;
    ws.xh = wr_x1_in < wr_x2_in ? wr_x2_in : wr_x1_in;
    ws.yl = wr_y1_in < wr_y2_in ? wr_y1_in : wr_y2_in;
    ws.yh = wr_y1_in < wr_y2_in ? wr_y2_in : wr_y1_in;
    ws.col = wr_color_in;
    ws.en = wr_enable_in;
    ws.ol = wr_outline_in;
  end

  always_comb begin
    hit1_d = 1'b0;
    idx1_d = '0;
    col1_d = '0;
    for (int i = NUM_RECTS - 1; i >= 0; i--)
      if (covers(active[i], hcount_in, vcount_in)) begin
        hit1_d = 1'b1;
        idx1_d = IW'(i);
        col1_d = active[i].col;
      end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_q <= 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      hit1_q <= 1'b0;
      idx1_q <= '0;
      col1_q <= '0;
      {red_out, green_out, blue_out} <= '0;
      hit_out <= 1'b0;
      hit_idx_out <= '0;
    end else begin
      ready_q <= 1'b1;
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (acc && wr_idx_in == IW'(i)) shadow[i] <= ws;
        if (new_frame_in) active[i] <= shadow[i];
      end
      hit1_q <= hit1_d;
      idx1_q <= idx1_d;
      col1_q <= col1_d;
      {red_out, green_out, blue_out} <= hit1_q ? col1_q : BG_COLOR;
      hit_out <= hit1_q;
      hit_idx_out <= idx1_q;
    end
  end
endmodule

// File: tb/tb_draw_rect_layers.sv
// tb_draw_rect_layers: randomized and directed checks against a behavioural compositor model
module tb_draw_rect_layers;
  localparam int N = 3;
  localparam int W = 2;
  localparam int BG = 0;

  logic clk = 0;
  logic rst = 1, nf = 0, valid = 0, en = 0, ol = 0;
  logic [1:0] idx = '0;
  logic [10:0] h = '0, x1 = '0, x2 = '0;
  logic [9:0] v = '0, y1 = '0, y2 = '0;
  logic [23:0] col = '0;
  logic ready, hit;
  logic [7:0] red, green, blue;
  logic [1:0] hit_idx;

  int passed = 0, total = 0;
  int sxl[N], sxh[N], syl[N], syh[N], scol[N];
  int axl[N], axh[N], ayl[N], ayh[N], acol[N];
  bit sen[N], sol[N], aen[N], aol[N];
  bit prev_rst = 1;
  int ep_rgb = 0, ep_hit = 0, ep_idx = 0;

  always #5 clk = ~clk;

  draw_rect_layers #(.NUM_RECTS(N), .OUTLINE_W(W), .BG_COLOR(24'(BG))) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(h), .vcount_in(v), .new_frame_in(nf),
    .wr_valid_in(valid), .wr_ready_out(ready), .wr_idx_in(idx),
    .wr_x1_in(x1), .wr_x2_in(x2), .wr_y1_in(y1), .wr_y2_in(y2),
    .wr_color_in(col), .wr_enable_in(en), .wr_outline_in(ol),
    .red_out(red), .green_out(green), .blue_out(blue), .hit_out(hit), .hit_idx_out(hit_idx)
  );

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask

  function automatic bit m_cov(int i, int px, int py);
    bit c, inner;
    c = aen[i] && px >= axl[i] && px < axh[i] && py >= ayl[i] && py < ayh[i];
    inner = px >= axl[i] + W && px < axh[i] - W && py >= ayl[i] + W && py < ayh[i] - W;
    return c && !(aol[i] && inner);
  endfunction

  task automatic step();
    bit rdy_e;
    int e_rgb, e_hit, e_idx, i;
    #1;
    rdy_e = !rst && !prev_rst && !nf;
    chk("ready", 32'(ready), 32'(rdy_e));
    e_rgb = BG; e_hit = 0; e_idx = 0;
    for (int k = N - 1; k >= 0; k--)
      if (m_cov(k, int'(h), int'(v))) begin
        e_rgb = acol[k]; e_hit = 1; e_idx = k;
      end
    if (rst) begin
      e_rgb = 0; e_hit = 0; e_idx = 0;
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        sxl[k] = 0; sxh[k] = 0; syl[k] = 0; syh[k] = 0; scol[k] = 0; sen[k] = 0; sol[k] = 0;
        axl[k] = 0; axh[k] = 0; ayl[k] = 0; ayh[k] = 0; acol[k] = 0; aen[k] = 0; aol[k] = 0;
      end
    end else begin
      i = int'(idx);
      if (valid && rdy_e && i < N) begin
        sxl[i] = x1 < x2 ? int'(x1) : int'(x2);
        sxh[i] = x1 < x2 ? int'(x2) : int'(x1);
        syl[i] = y1 < y2 ? int'(y1) : int'(y2);
        syh[i] = y1 < y2 ? int'(y2) : int'(y1);
        scol[i] = int'(col); sen[i] = en; sol[i] = ol;
      end
      if (nf)
        for (int k = 0; k < N; k++) begin
          axl[k] = sxl[k]; axh[k] = sxh[k]; ayl[k] = syl[k]; ayh[k] = syh[k];
          acol[k] = scol[k]; aen[k] = sen[k]; aol[k] = sol[k];
        end
    end
    prev_rst = rst;
    #1;
    chk("rgb", 32'({red, green, blue}), rst ? 32'(0) : 32'(ep_rgb));
    chk("hit", 32'(hit), rst ? 32'(0) : 32'(ep_hit));
    chk("hit_idx", 32'(hit_idx), rst ? 32'(0) : 32'(ep_idx));
    ep_rgb = e_rgb; ep_hit = e_hit; ep_idx = e_idx;
  endtask

  task automatic wr(int i, int ax1, int ay1, int ax2, int ay2, int c, bit e, bit o);
    idx = 2'(i); x1 = 11'(ax1); y1 = 10'(ay1); x2 = 11'(ax2); y2 = 10'(ay2);
    col = 24'(c); en = e; ol = o; valid = 1; nf = 0;
    step();
    valid = 0;
  endtask

  task automatic commit();
    nf = 1;
    step();
    nf = 0;
  endtask

  task automatic px(string nm, int ph, int pv, int e_rgb, int e_hit, int e_idx);
    h = 11'(ph); v = 10'(pv);
    step();
    step();
    chk({nm, "_rgb"}, 32'({red, green, blue}), 32'(e_rgb));
    chk({nm, "_hit"}, 32'(hit), 32'(e_hit));
    chk({nm, "_idx"}, 32'(hit_idx), 32'(e_idx));
  endtask

  initial begin
    repeat (3) step();
    chk("reset_rgb", 32'({red, green, blue}), 32'(0));
    chk("reset_ready", 32'(ready), 32'(0));
    rst = 0;
    step();
    step();
    wr(0, 10, 20, 50, 60, 24'hFF0000, 1, 0);
    px("pre_commit", 30, 30, BG, 0, 0);
    commit();
    px("commit_hit", 30, 30, 24'hFF0000, 1, 0);
    px("x_hi_excl", 50, 30, BG, 0, 0);
    wr(0, 50, 60, 10, 20, 24'hFF0000, 1, 0);
    commit();
    px("rev_lo", 10, 20, 24'hFF0000, 1, 0);
    px("rev_hi", 49, 59, 24'hFF0000, 1, 0);
    px("rev_y_excl", 30, 60, BG, 0, 0);
    wr(0, 0, 0, 100, 100, 24'hFF0000, 1, 0);
    wr(1, 50, 50, 150, 150, 24'h00FF00, 1, 0);
    commit();
    px("ovl_red", 75, 75, 24'hFF0000, 1, 0);
    px("ovl_green", 120, 120, 24'h00FF00, 1, 1);
    wr(0, 10, 10, 20, 20, 24'h0000FF, 1, 1);
    wr(1, 0, 0, 0, 0, 0, 0, 0);
    commit();
    px("ol_edge", 11, 15, 24'h0000FF, 1, 0);
    px("ol_inner", 15, 15, BG, 0, 0);
    px("ol_corner", 19, 19, 24'h0000FF, 1, 0);
    wr(0, 10, 10, 13, 13, 24'h0000FF, 1, 1);
    commit();
    px("ol_small_a", 12, 12, 24'h0000FF, 1, 0);
    px("ol_small_b", 11, 11, 24'h0000FF, 1, 0);
    idx = 2; x1 = 0; y1 = 0; x2 = 5; y2 = 5; col = 24'h123456; en = 1; ol = 0;
    valid = 1; nf = 1;
    step();
    chk("ready_nf", 32'(ready), 32'(0));
    nf = 0;
    step();
    valid = 0;
    commit();
    px("held_write", 2, 2, 24'h123456, 1, 2);
    wr(3, 0, 0, 10, 10, 24'hFFFFFF, 1, 0);
    commit();
    px("bad_idx", 2, 2, 24'h123456, 1, 2);
    wr(2, 0, 0, 5, 5, 24'h123456, 0, 0);
    h = 2; v = 2; nf = 1;
    step();
    nf = 0;
    step();
    chk("nf_old_bank", 32'(hit), 32'(1));
    step();
    chk("nf_new_bank", 32'(hit), 32'(0));
    repeat (3000) begin
      rst = $urandom_range(0, 299) == 0;
      nf = $urandom_range(0, 15) == 0;
      valid = $urandom_range(0, 2) == 0;
      idx = 2'($urandom_range(0, 3));
      x1 = 11'($urandom_range(0, 160)); x2 = 11'($urandom_range(0, 160));
      y1 = 10'($urandom_range(0, 160)); y2 = 10'($urandom_range(0, 160));
      h = 11'($urandom_range(0, 170)); v = 10'($urandom_range(0, 170));
      col = 24'($urandom);
      en = $urandom_range(0, 3) != 0;
      ol = $urandom_range(0, 2) == 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
